// File: rtl/stopwatch_clkdiv.sv
// Stopwatch prescaler: turns the 16 MHz system clock into a one-cycle 1 ms enable strobe.
// The strobe is a clock enable for the ms/s/min counters and is never used as a clock.
module stopwatch_clkdiv #(
  parameter  int DIV   = 16000,
  localparam int CNT_W = $clog2(DIV)
) (
  input  logic I_CLK,
  input  logic I_RSTN,
  input  logic I_START_EN,
  input  logic I_CLEAR_EN,
  output logic O_EN_1MS
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q,  en_d;

  // Clear beats start; a paused counter keeps its phase so elapsed time survives pauses.
  always_comb begin
    cnt_d = cnt_q;
    en_d  = 1'b0;
    if (I_CLEAR_EN) begin
      cnt_d = '0;
    end else if (I_START_EN) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        en_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
    end
  end

  assign O_EN_1MS = en_q;

endmodule

// File: tb/tb_stopwatch_clkdiv.sv
// Bench for stopwatch_clkdiv: DIV=8, DIV=2 and default DIV instances share one clock and reset,
// and a per-cycle elapsed-time model fills a scoreboard that is drained after every clock edge.
`timescale 1ns/1ps
module tb_stopwatch_clkdiv;

  logic clk = 1'b0;
  logic rstn;
  logic clear;
  logic start8, start2, start16;
  logic o8, o2, o16;

  int vectors = 0;
  int miscompares = 0;
  int e8 = 0, e2 = 0, e16 = 0;
  logic o2_prev = 1'b0;
  logic [31:0] sb[$];

  always #31.25 clk = ~clk;

  stopwatch_clkdiv #(.DIV(8)) dut8 (
    .I_CLK(clk), .I_RSTN(rstn), .I_START_EN(start8), .I_CLEAR_EN(clear), .O_EN_1MS(o8));
  stopwatch_clkdiv #(.DIV(2)) dut2 (
    .I_CLK(clk), .I_RSTN(rstn), .I_START_EN(start2), .I_CLEAR_EN(clear), .O_EN_1MS(o2));
  stopwatch_clkdiv dut16 (
    .I_CLK(clk), .I_RSTN(rstn), .I_START_EN(start16), .I_CLEAR_EN(clear), .O_EN_1MS(o16));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Strobe fires on the counted edge that completes a whole number of periods of elapsed time.
  function automatic logic strobe_of(input int div, input int e, input logic s, input logic c);
    return !c && s && ((e + 1) % div == 0);
  endfunction

  function automatic int elapsed_of(input int div, input int e, input logic s, input logic c);
    if (c) return 0;
    if (s) return (e + 1) % div;
    return e;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic s8, input logic s2, input logic s16, input logic clr);
    start8 = s8; start2 = s2; start16 = s16; clear = clr;
    sb.push_back(32'(strobe_of(8, e8, s8, clr)));
    e8 = elapsed_of(8, e8, s8, clr);
    sb.push_back(32'(e8));
    sb.push_back(32'(strobe_of(2, e2, s2, clr)));
    e2 = elapsed_of(2, e2, s2, clr);
    sb.push_back(32'(strobe_of(16000, e16, s16, clr)));
    e16 = elapsed_of(16000, e16, s16, clr);
    @(posedge clk);
    #1;
    chk("o8", 32'(o8), sb.pop_front());
    chk("cnt8", 32'(dut8.cnt_q), sb.pop_front());
    chk("o2", 32'(o2), sb.pop_front());
    chk("o2_no_double", 32'(o2 & o2_prev), 32'd0);
    chk("o16000", 32'(o16), sb.pop_front());
    o2_prev = o2;
    @(negedge clk);
  endtask

  task automatic run8(input int n, input logic s, input logic clr);
    for (int i = 0; i < n; i++) step(s, 1'b0, 1'b0, clr);
  endtask

  task automatic async_reset_check(input string tag);
    #10;
    rstn = 1'b0;
    e8 = 0; e2 = 0; e16 = 0;
    #1;
    chk({tag, "_o8"}, 32'(o8), 32'd0);
    chk({tag, "_cnt8"}, 32'(dut8.cnt_q), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  int pulses16;

  initial begin
    rstn = 1'b0; clear = 1'b0; start8 = 1'b0; start2 = 1'b0; start16 = 1'b0;
    @(negedge clk);

    // Reset held with inputs toggling.
    for (int i = 0; i < 10; i++) begin
      start8 = i[0]; start2 = i[0]; start16 = i[0]; clear = i[1];
      @(posedge clk);
      #1;
      chk("rst_hold_o8", 32'(o8), 32'd0);
      chk("rst_hold_cnt8", 32'(dut8.cnt_q), 32'd0);
      chk("rst_hold_o2", 32'(o2), 32'd0);
      @(negedge clk);
    end
    rstn = 1'b1;

    // Free run: strobes after edges 8, 16, 24.
    run8(24, 1'b1, 1'b0);

    // Clear: run 5, clear 20, release, then clear 3 cycles before the next pulse.
    run8(5, 1'b1, 1'b0);
    run8(20, 1'b1, 1'b1);
    run8(8, 1'b1, 1'b0);
    run8(5, 1'b1, 1'b0);
    run8(3, 1'b1, 1'b1);
    run8(10, 1'b1, 1'b0);

    // Pause/resume: phase 5 held for 10 cycles, pulse 3 edges after resuming.
    run8(1, 1'b1, 1'b1);
    run8(5, 1'b1, 1'b0);
    run8(10, 1'b0, 1'b0);
    run8(3, 1'b1, 1'b0);
    run8(4, 1'b0, 1'b0);

    // Clear coincident with the wrap edge wins.
    run8(7, 1'b1, 1'b0);
    run8(1, 1'b1, 1'b1);
    // Start drops right after the wrap edge: one strobe, phase 0, then nothing.
    run8(7, 1'b1, 1'b0);
    run8(1, 1'b1, 1'b0);
    run8(6, 1'b0, 1'b0);

    // Asynchronous reset while the strobe is high, then mid-count.
    run8(8, 1'b1, 1'b0);
    async_reset_check("areset_strobe");
    run8(5, 1'b1, 1'b0);
    async_reset_check("areset_mid");
    run8(9, 1'b1, 1'b0);

    // DIV=2 boundary.
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 1'b0);

    // Default DIV: two full 1 ms periods.
    pulses16 = 0;
    for (int i = 0; i < 32000; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      if (o16) pulses16++;
    end
    chk("pulses16000", 32'(pulses16), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
